// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl
//   Round controller and buzzer arbiter for the multichannel answering machine.
//   Latches the player count, countdown length and point values from the
//   settings block, arbitrates up to four buzz buttons per question, runs the
//   per-second countdown, applies host judgement to the per-player scores and
//   handles false-start and wrong-answer lockouts.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   is_set_over       configuration complete (level); low forces CFG_WAIT
//   num_people        active players (valid 2..4); player i active if i < num_people
//   count_seconds     countdown length per question, seconds
//   corrcet_point     points added on a correct answer
//   mistake_point     points subtracted on a wrong answer
//   start_btn         host opens a question (1-cycle pulse)
//   buzz[3:0]         synchronized player buttons, bit i = player i
//   judge_ok/bad      host judgement pulses; both together are ignored
//   state             CFG_WAIT=0 READY=1 OPEN=2 ANSWER=3 ROUND_END=4
//   winner, winner_valid  player currently answering
//   remaining         seconds left in the countdown
//   lockout[3:0]      players barred for the current question
//   scores            player i score at [i*SCORE_W +: SCORE_W]
//   alarm             1-cycle pulse on false start or timeout
//   round_done        1-cycle pulse while the question ends
module quiz_round_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned SCORE_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 is_set_over,
  input  logic [5:0]           num_people,
  input  logic [5:0]           count_seconds,
  input  logic [5:0]           corrcet_point,
  input  logic [5:0]           mistake_point,
  input  logic                 start_btn,
  input  logic [3:0]           buzz,
  input  logic                 judge_ok,
  input  logic                 judge_bad,
  output logic [2:0]           state,
  output logic [1:0]           winner,
  output logic                 winner_valid,
  output logic [5:0]           remaining,
  output logic [3:0]           lockout,
  output logic [4*SCORE_W-1:0] scores,
  output logic                 alarm,
  output logic                 round_done
);

  typedef enum logic [2:0] {
    CFG_WAIT  = 3'd0,
    READY     = 3'd1,
    OPEN      = 3'd2,
    ANSWER    = 3'd3,
    ROUND_END = 3'd4
  } state_t;

  localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t             state_q, state_d;
  logic [3:0]         buzz_q;
  logic [5:0]         np_q, np_d;
  logic [5:0]         secs_q, secs_d;
  logic [5:0]         corr_q, corr_d;
  logic [5:0]         mis_q, mis_d;
  logic [1:0]         winner_q, winner_d;
  logic               wv_q, wv_d;
  logic [5:0]         rem_q, rem_d;
  logic [3:0]         lock_q, lock_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               alarm_q, alarm_d;
  logic [SCORE_W-1:0] score_q [4];
  logic [SCORE_W-1:0] score_d [4];

  logic [3:0]         active;
  logic [3:0]         press;
  logic [3:0]         press_act;
  logic [3:0]         valid;
  logic [1:0]         win_idx;
  logic               win_found;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W:0]   add_sum;
  logic [SCORE_W:0]   sub_diff;
  logic [3:0]         lock_after_bad;

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      active[i] = (i < 32'(np_q));
    end
  end

  assign press     = buzz & ~buzz_q;
  assign press_act = press & active;
  assign valid     = press_act & ~lock_q;

  // Lowest-index valid press wins a same-cycle tie.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (valid[i] && !win_found) begin
        win_idx   = 2'(i);
        win_found = 1'b1;
      end
    end
  end

  // One extra bit catches overflow (saturate high) and borrow (floor at 0).
  assign cur_score      = score_q[winner_q];
  assign add_sum        = {1'b0, cur_score} + (SCORE_W+1)'(corr_q);
  assign sub_diff       = {1'b0, cur_score} - (SCORE_W+1)'(mis_q);
  assign lock_after_bad = lock_q | (4'b0001 << winner_q);

  always_comb begin
    state_d  = state_q;
    np_d     = np_q;
    secs_d   = secs_q;
    corr_d   = corr_q;
    mis_d    = mis_q;
    winner_d = winner_q;
    wv_d     = wv_q;
    rem_d    = rem_q;
    lock_d   = lock_q;
    pre_d    = pre_q;
    alarm_d  = 1'b0;
    score_d  = score_q;

    if (!is_set_over) begin
      state_d  = CFG_WAIT;
      winner_d = '0;
      wv_d     = 1'b0;
      rem_d    = '0;
      lock_d   = '0;
      pre_d    = '0;
      for (int unsigned i = 0; i < 4; i++) score_d[i] = '0;
    end else begin
      case (state_q)
        CFG_WAIT: begin
          np_d    = num_people;
          secs_d  = count_seconds;
          corr_d  = corrcet_point;
          mis_d   = mistake_point;
          for (int unsigned i = 0; i < 4; i++) score_d[i] = '0;
          state_d = READY;
        end
        READY: begin
          if (|press_act) begin
            lock_d  = lock_q | press_act;
            alarm_d = 1'b1;
          end
          if (start_btn) begin
            rem_d   = secs_q;
            pre_d   = '0;
            state_d = OPEN;
          end
        end
        OPEN: begin
          // A valid press takes priority over a coinciding final tick.
          if (win_found) begin
            winner_d = win_idx;
            wv_d     = 1'b1;
            state_d  = ANSWER;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (rem_q <= 6'd1) begin
              rem_d   = '0;
              alarm_d = 1'b1;
              state_d = ROUND_END;
            end else begin
              rem_d = rem_q - 6'd1;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        ANSWER: begin
          if (judge_ok && !judge_bad) begin
            score_d[winner_q] = add_sum[SCORE_W] ? '1 : add_sum[SCORE_W-1:0];
            state_d = ROUND_END;
          end else if (judge_bad && !judge_ok) begin
            score_d[winner_q] = sub_diff[SCORE_W] ? '0 : sub_diff[SCORE_W-1:0];
            lock_d  = lock_after_bad;
            wv_d    = 1'b0;
            state_d = ((lock_after_bad & active) == active) ? ROUND_END : OPEN;
          end
        end
        ROUND_END: begin
          lock_d  = '0;
          wv_d    = 1'b0;
          rem_d   = '0;
          state_d = READY;
        end
        default: state_d = CFG_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CFG_WAIT;
      buzz_q   <= '0;
      np_q     <= '0;
      secs_q   <= '0;
      corr_q   <= '0;
      mis_q    <= '0;
      winner_q <= '0;
      wv_q     <= 1'b0;
      rem_q    <= '0;
      lock_q   <= '0;
      pre_q    <= '0;
      alarm_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) score_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      buzz_q   <= buzz;
      np_q     <= np_d;
      secs_q   <= secs_d;
      corr_q   <= corr_d;
      mis_q    <= mis_d;
      winner_q <= winner_d;
      wv_q     <= wv_d;
      rem_q    <= rem_d;
      lock_q   <= lock_d;
      pre_q    <= pre_d;
      alarm_q  <= alarm_d;
      for (int unsigned i = 0; i < 4; i++) score_q[i] <= score_d[i];
    end
  end

  assign state        = state_q;
  assign winner       = winner_q;
  assign winner_valid = wv_q;
  assign remaining    = rem_q;
  assign lockout      = lock_q;
  assign alarm        = alarm_q;
  assign round_done   = (state_q == ROUND_END);

  always_comb begin
    scores = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      scores[i*SCORE_W +: SCORE_W] = score_q[i];
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Testbench for quiz_round_ctrl: directed scenarios with literal expectations
// followed by randomized stimulus, all checked every cycle against an
// integer-level behavioural model of the round rules.
module tb_quiz_round_ctrl;

  localparam int TICK = 4;
  localparam int SW   = 8;
  localparam int SMAX = (1 << SW) - 1;
  localparam int S_CFG = 0, S_RDY = 1, S_OPEN = 2, S_ANS = 3, S_END = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          is_set_over;
  logic [5:0]    num_people, count_seconds, corrcet_point, mistake_point;
  logic          start_btn;
  logic [3:0]    buzz;
  logic          judge_ok, judge_bad;
  logic [2:0]    state;
  logic [1:0]    winner;
  logic          winner_valid;
  logic [5:0]    remaining;
  logic [3:0]    lockout;
  logic [4*SW-1:0] scores;
  logic          alarm, round_done;

  quiz_round_ctrl #(.TICK_DIV(TICK), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .is_set_over(is_set_over),
    .num_people(num_people), .count_seconds(count_seconds),
    .corrcet_point(corrcet_point), .mistake_point(mistake_point),
    .start_btn(start_btn), .buzz(buzz), .judge_ok(judge_ok), .judge_bad(judge_bad),
    .state(state), .winner(winner), .winner_valid(winner_valid),
    .remaining(remaining), .lockout(lockout), .scores(scores),
    .alarm(alarm), .round_done(round_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int       m_st, m_np, m_secs, m_corr, m_mis, m_rem, m_pre, m_win;
  bit       m_wv, m_alarm;
  bit [3:0] m_lock, m_prev;
  int       m_score [4];

  task automatic model_clear();
    m_st = S_CFG; m_win = 0; m_wv = 0; m_rem = 0; m_lock = '0; m_pre = 0; m_alarm = 0;
    for (int i = 0; i < 4; i++) m_score[i] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_prev = '0; m_np = 0; m_secs = 0; m_corr = 0; m_mis = 0;
  endtask

  task automatic model_step();
    bit [3:0] pr;
    int nact, first, nlocked;
    pr     = buzz & ~m_prev;
    m_prev = buzz;
    nact   = (m_np > 4) ? 4 : m_np;
    m_alarm = 0;
    if (!is_set_over) begin
      model_clear();
    end else begin
      case (m_st)
        S_CFG: begin
          m_np = int'(num_people); m_secs = int'(count_seconds);
          m_corr = int'(corrcet_point); m_mis = int'(mistake_point);
          for (int i = 0; i < 4; i++) m_score[i] = 0;
          m_st = S_RDY;
        end
        S_RDY: begin
          for (int i = 0; i < nact; i++)
            if (pr[i]) begin m_lock[i] = 1; m_alarm = 1; end
          if (start_btn) begin m_rem = m_secs; m_pre = 0; m_st = S_OPEN; end
        end
        S_OPEN: begin
          first = -1;
          for (int i = 0; i < nact; i++)
            if (pr[i] && !m_lock[i] && first < 0) first = i;
          if (first >= 0) begin
            m_win = first; m_wv = 1; m_st = S_ANS;
          end else begin
            m_pre++;
            if (m_pre == TICK) begin
              m_pre = 0;
              if (m_rem <= 1) begin m_rem = 0; m_alarm = 1; m_st = S_END; end
              else m_rem--;
            end
          end
        end
        S_ANS: begin
          if (judge_ok && !judge_bad) begin
            m_score[m_win] = (m_score[m_win] + m_corr > SMAX) ? SMAX : m_score[m_win] + m_corr;
            m_st = S_END;
          end else if (judge_bad && !judge_ok) begin
            m_score[m_win] = (m_score[m_win] < m_mis) ? 0 : m_score[m_win] - m_mis;
            m_lock[m_win] = 1; m_wv = 0;
            nlocked = 0;
            for (int i = 0; i < nact; i++) if (m_lock[i]) nlocked++;
            m_st = (nlocked == nact) ? S_END : S_OPEN;
          end
        end
        S_END: begin
          m_lock = '0; m_wv = 0; m_rem = 0; m_st = S_RDY;
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n && cmp_en) begin
      chk("state", int'(state), m_st);
      chk("winner", int'(winner), m_win);
      chk("winner_valid", int'(winner_valid), int'(m_wv));
      chk("remaining", int'(remaining), m_rem);
      chk("lockout", int'(lockout), int'(m_lock));
      chk("alarm", int'(alarm), int'(m_alarm));
      chk("round_done", int'(round_done), (m_st == S_END) ? 1 : 0);
      for (int i = 0; i < 4; i++)
        chk($sformatf("score%0d", i), int'(scores[i*SW +: SW]), m_score[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    start_btn = 1'b1; @(negedge clk); start_btn = 1'b0;
  endtask
  task automatic pulse_ok();
    judge_ok = 1'b1; @(negedge clk); judge_ok = 1'b0;
  endtask
  task automatic pulse_bad();
    judge_bad = 1'b1; @(negedge clk); judge_bad = 1'b0;
  endtask
  task automatic press(input int p);
    buzz = 4'b0001 << p; @(negedge clk); buzz = '0;
  endtask
  task automatic round_ok(input int p);
    pulse_start(); press(p); pulse_ok(); @(negedge clk);
  endtask
  task automatic round_bad0();
    pulse_start(); press(0); pulse_bad(); press(1); pulse_ok(); @(negedge clk);
  endtask

  function automatic int sc(input int p);
    return int'(scores[p*SW +: SW]);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst_n = 1'b0; is_set_over = 1'b0; start_btn = 1'b0; buzz = '0;
    judge_ok = 1'b0; judge_bad = 1'b0;
    num_people = 6'd3; count_seconds = 6'd5; corrcet_point = 6'd3; mistake_point = 6'd2;
    repeat (2) @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_scores", int'(scores), 0);
    chk("reset_remaining", int'(remaining), 0);
    rst_n = 1'b1; cmp_en = 1'b1;
    @(negedge clk);

    // Configure and open the first question.
    is_set_over = 1'b1;
    @(negedge clk);
    chk("cfg_ready", int'(state), S_RDY);
    pulse_start();
    chk("open_state", int'(state), S_OPEN);
    chk("open_remaining", int'(remaining), 5);
    chk("model_rem_pin", m_rem, 5);
    repeat (4) @(negedge clk);
    chk("tick_remaining", int'(remaining), 4);

    // Simultaneous presses by players 2 and 1: lower index wins.
    buzz = 4'b0110; @(negedge clk);
    chk("tie_state", int'(state), S_ANS);
    chk("tie_winner", int'(winner), 1);
    chk("tie_valid", int'(winner_valid), 1);
    buzz = '0;
    pulse_ok();
    chk("ok_round_done", int'(round_done), 1);
    chk("ok_score1", sc(1), 3);
    @(negedge clk);
    chk("ok_ready", int'(state), S_RDY);
    chk("ok_rd_low", int'(round_done), 0);

    // False start by player 0.
    buzz = 4'b0001; @(negedge clk);
    chk("fs_alarm", int'(alarm), 1);
    chk("fs_lockout", int'(lockout), 1);
    buzz = '0; @(negedge clk);
    chk("fs_alarm_pulse", int'(alarm), 0);
    pulse_start();
    buzz = 4'b0001; @(negedge clk);
    chk("fs_locked_ignored", int'(state), S_OPEN);
    buzz = 4'b0011; @(negedge clk);
    chk("fs_p1_wins", int'(winner), 1);
    chk("fs_p1_state", int'(state), S_ANS);
    buzz = '0;
    pulse_ok(); @(negedge clk);
    chk("fs_lock_cleared", int'(lockout), 0);
    chk("model_score1_pin", m_score[1], 6);

    // Player 2 wrong with zero score, inactive player 3 ignored, then timeout.
    pulse_start();
    press(2);
    chk("p2_winner", int'(winner), 2);
    pulse_bad();
    chk("bad_state", int'(state), S_OPEN);
    chk("bad_floor", sc(2), 0);
    chk("bad_lockout", int'(lockout), 4);
    chk("bad_remaining", int'(remaining), 5);
    press(3);
    chk("inactive_ignored", int'(state), S_OPEN);
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (round_done) got = 1'b1;
    end
    chk("timeout_seen", int'(got), 1);
    if (got) chk("timeout_alarm", int'(alarm), 1);
    @(negedge clk);
    chk("timeout_ready", int'(state), S_RDY);

    // Every active player answers wrong.
    pulse_start();
    press(0); pulse_bad();
    press(1); pulse_bad();
    press(2); pulse_bad();
    chk("all_bad_end", int'(state), S_END);
    chk("all_bad_lock", int'(lockout), 7);
    chk("all_bad_score1", sc(1), 4);
    @(negedge clk);
    chk("all_bad_ready", int'(state), S_RDY);
    chk("all_bad_cleared", int'(lockout), 0);

    // Walk player 0 to 254, then saturate.
    for (int r = 0; r < 84; r++) round_ok(0);
    chk("sat_252", sc(0), 252);
    round_bad0(); round_ok(0); round_bad0(); round_ok(0);
    chk("sat_254", sc(0), 254);
    round_ok(0);
    chk("sat_255", sc(0), 255);

    // Configuration dropped mid-answer.
    pulse_start(); press(0);
    chk("drop_in_answer", int'(state), S_ANS);
    is_set_over = 1'b0; @(negedge clk);
    chk("drop_state", int'(state), S_CFG);
    chk("drop_scores", int'(scores), 0);
    chk("drop_valid", int'(winner_valid), 0);
    is_set_over = 1'b1; @(negedge clk);
    chk("relatch_ready", int'(state), S_RDY);

    // Asynchronous reset mid-question.
    pulse_start(); repeat (2) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("arst_state", int'(state), 0);
    chk("arst_remaining", int'(remaining), 0);
    chk("arst_round_done", int'(round_done), 0);
    chk("arst_scores", int'(scores), 0);
    chk("arst_alarm", int'(alarm), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Randomized phase.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) buzz = 4'($urandom_range(0, 15));
      start_btn   = ($urandom_range(0, 7) == 0);
      judge_ok    = ($urandom_range(0, 4) == 0);
      judge_bad   = ($urandom_range(0, 4) == 0);
      is_set_over = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) begin
        num_people    = 6'($urandom_range(1, 5));
        count_seconds = 6'($urandom_range(1, 6));
        corrcet_point = 6'($urandom_range(0, 63));
        mistake_point = 6'($urandom_range(0, 63));
      end
    end
    @(negedge clk);
    buzz = '0; start_btn = 1'b0; judge_ok = 1'b0; judge_bad = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
